// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared defaults and next-PC select encoding for the PC unit.
package pc_sequencer_pkg;
   localparam int PC_WIDTH_DEF = 8;
   localparam int RESET_PC_DEF = 0;
   typedef logic [1:0] pc_sel_t;
   localparam pc_sel_t SEL_INC  = 2'd0;
   localparam pc_sel_t SEL_JMP  = 2'd1;
   localparam pc_sel_t SEL_RET  = 2'd2;
   localparam pc_sel_t SEL_HOLD = 2'd3;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address LIFO with occupancy flags and a registered overflow/underflow pulse.
module pc_ras #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty,
   output logic             err
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             do_push, do_pop;
   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~pop & ~full;
   // DEPTH is a power of two, so the low bits of count wrap to the last slot when full
   assign top     = mem_q[cnt_q[AW-1:0] - 1'b1];
   assign err     = err_q;
   always_comb begin
      cnt_d = do_pop ? cnt_q - 1'b1 : do_push ? cnt_q + 1'b1 : cnt_q;
      err_d = (pop & empty) | (push & ~pop & full);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[cnt_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with prioritised next-PC select and a return-address stack.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH_DEF,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus1,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);
   logic [WIDTH-1:0] pc_q, pc_d, ras_top;
   pc_sel_t          sel;
   logic             push, pop;
   assign pc       = pc_q;
   assign pc_plus1 = pc_q + 1'b1;
   // ret outranks call, so a call is only forwarded to the stack when ret is idle
   assign pop  = ~stall & ret;
   assign push = ~stall & ~ret & call;
   always_comb begin
      sel  = stall ? SEL_HOLD : ret ? (ras_empty ? SEL_INC : SEL_RET) : (call | jump) ? SEL_JMP : SEL_INC;
      pc_d = sel == SEL_HOLD ? pc_q : sel == SEL_RET ? ras_top : sel == SEL_JMP ? target : pc_plus1;
   end
   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end
   pc_ras #(.DEPTH(RAS_DEPTH), .WIDTH(WIDTH)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_plus1),
      .top   (ras_top),
      .full  (ras_full),
      .empty (ras_empty),
      .err   (ras_err)
   );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenario bench for pc_sequencer (WIDTH=8, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;
   logic       clk = 1'b0;
   logic       reset, stall, jump, call, ret;
   logic [7:0] target, pc, pc_plus1;
   logic       ras_empty, ras_full, ras_err;
   int         tests = 0;
   int         fails = 0;

   pc_sequencer #(.WIDTH(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .jump      (jump),
      .call      (call),
      .ret       (ret),
      .target    (target),
      .pc        (pc),
      .pc_plus1  (pc_plus1),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_err   (ras_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {reset, stall, jump, call, ret} = '0;
   endtask

   task automatic jump_to(input logic [7:0] a);
      idle(); jump = 1'b1; target = a; step(); idle();
   endtask

   task automatic test_reset();
      idle(); target = 8'h00; reset = 1'b1; step(); idle();
      tests++; if (pc !== 8'h00) begin fails++; $display("FAIL reset_pc got %h exp 00", pc); end
      tests++; if (pc_plus1 !== 8'h01) begin fails++; $display("FAIL reset_pc_plus1 got %h exp 01", pc_plus1); end
      tests++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin fails++; $display("FAIL reset_flags got %b exp 100", {ras_empty, ras_full, ras_err}); end
      for (int i = 1; i <= 3; i++) begin
         step();
         tests++; if (pc !== 8'(i)) begin fails++; $display("FAIL idle_pc got %h exp %h", pc, 8'(i)); end
      end
      tests++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin fails++; $display("FAIL idle_flags got %b%b exp 10", ras_empty, ras_err); end
      reset = 1'b1; step(); idle();
      tests++; if (pc !== 8'h00) begin fails++; $display("FAIL rereset_pc got %h exp 00", pc); end
   endtask

   task automatic test_jump_stall();
      step(); step();
      tests++; if (pc !== 8'h02) begin fails++; $display("FAIL pre_jump_pc got %h exp 02", pc); end
      jump_to(8'h7C);
      tests++; if (pc !== 8'h7C) begin fails++; $display("FAIL jump_pc got %h exp 7c", pc); end
      tests++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL jump_ras got %b exp 1", ras_empty); end
      step();
      tests++; if (pc !== 8'h7D) begin fails++; $display("FAIL jump_inc got %h exp 7d", pc); end
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         tests++; if (pc !== 8'h7D) begin fails++; $display("FAIL stall_pc got %h exp 7d", pc); end
      end
      idle();
   endtask

   task automatic test_call_ret();
      jump_to(8'h10);
      call = 1'b1; target = 8'h40; step(); idle();
      tests++; if (pc !== 8'h40 || ras_empty !== 1'b0) begin fails++; $display("FAIL call_pc got %h/%b exp 40/0", pc, ras_empty); end
      step(); step();
      tests++; if (pc !== 8'h42) begin fails++; $display("FAIL call_idle got %h exp 42", pc); end
      ret = 1'b1; step(); idle();
      tests++; if (pc !== 8'h11 || ras_empty !== 1'b1) begin fails++; $display("FAIL ret_pc got %h/%b exp 11/1", pc, ras_empty); end
   endtask

   task automatic test_nested();
      logic [7:0] exp_ret;
      jump_to(8'h20);
      for (int i = 0; i < 4; i++) begin
         call = 1'b1; target = 8'(8'h30 + 8'h10 * i); step(); idle();
      end
      tests++; if (pc !== 8'h60 || ras_full !== 1'b1 || ras_err !== 1'b0) begin fails++; $display("FAIL nest_full got %h/%b/%b exp 60/1/0", pc, ras_full, ras_err); end
      call = 1'b1; target = 8'h99; step(); idle();
      tests++; if (pc !== 8'h99 || ras_err !== 1'b1 || ras_full !== 1'b1) begin fails++; $display("FAIL overflow got %h/%b/%b exp 99/1/1", pc, ras_err, ras_full); end
      step();
      tests++; if (pc !== 8'h9A || ras_err !== 1'b0) begin fails++; $display("FAIL overflow_pulse got %h/%b exp 9a/0", pc, ras_err); end
      exp_ret = 8'h51;
      for (int i = 0; i < 4; i++) begin
         ret = 1'b1; step(); idle();
         tests++; if (pc !== exp_ret || ras_err !== 1'b0) begin fails++; $display("FAIL nest_ret got %h/%b exp %h/0", pc, ras_err, exp_ret); end
         exp_ret = exp_ret - 8'h10;
      end
      tests++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin fails++; $display("FAIL nest_empty got %b%b exp 10", ras_empty, ras_full); end
   endtask

   task automatic test_underflow();
      jump_to(8'h05);
      ret = 1'b1; step(); idle();
      tests++; if (pc !== 8'h06 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin fails++; $display("FAIL underflow got %h/%b/%b exp 06/1/1", pc, ras_err, ras_empty); end
      step();
      tests++; if (pc !== 8'h07 || ras_err !== 1'b0) begin fails++; $display("FAIL underflow_pulse got %h/%b exp 07/0", pc, ras_err); end
      stall = 1'b1; ret = 1'b1; step(); idle();
      tests++; if (pc !== 8'h07 || ras_err !== 1'b0) begin fails++; $display("FAIL stall_ret got %h/%b exp 07/0", pc, ras_err); end
   endtask

   task automatic test_wrap_conflict();
      jump_to(8'hFF);
      tests++; if (pc_plus1 !== 8'h00) begin fails++; $display("FAIL wrap_plus1 got %h exp 00", pc_plus1); end
      step();
      tests++; if (pc !== 8'h00) begin fails++; $display("FAIL wrap_pc got %h exp 00", pc); end
      jump_to(8'hFF);
      call = 1'b1; target = 8'h10; step(); idle();
      ret = 1'b1; step(); idle();
      tests++; if (pc !== 8'h00) begin fails++; $display("FAIL wrap_push got %h exp 00", pc); end
      jump_to(8'h32);
      call = 1'b1; jump = 1'b1; target = 8'h80; step(); idle();
      tests++; if (pc !== 8'h80 || ras_empty !== 1'b0) begin fails++; $display("FAIL call_jump got %h/%b exp 80/0", pc, ras_empty); end
      call = 1'b1; ret = 1'b1; target = 8'h55; step(); idle();
      tests++; if (pc !== 8'h33 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin fails++; $display("FAIL call_ret got %h/%b/%b exp 33/1/0", pc, ras_empty, ras_err); end
      stall = 1'b1; call = 1'b1; target = 8'h77; step(); idle();
      tests++; if (pc !== 8'h33 || ras_empty !== 1'b1) begin fails++; $display("FAIL stall_call got %h/%b exp 33/1", pc, ras_empty); end
   endtask

   task automatic test_reset_override();
      call = 1'b1; target = 8'h44; step(); idle();
      stall = 1'b1; reset = 1'b1; call = 1'b1; step(); idle();
      tests++; if (pc !== 8'h00 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin fails++; $display("FAIL reset_stall got %h/%b/%b exp 00/1/0", pc, ras_empty, ras_err); end
      ret = 1'b1; step(); idle();
      reset = 1'b1; step(); idle();
      tests++; if (pc !== 8'h00 || ras_err !== 1'b0) begin fails++; $display("FAIL reset_err got %h/%b exp 00/0", pc, ras_err); end
   endtask

   initial begin
      idle(); target = 8'h00;
      test_reset();
      test_jump_stall();
      test_call_ret();
      test_nested();
      test_underflow();
      test_wrap_conflict();
      test_reset_override();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
